// File: rtl/scan_chain_loader_if.sv
// Word handshake and readback bus between a bitstream source and scan_chain_loader.
// The source drives WDATA/WVALID; the loader answers with WREADY and returns
// the old chain contents on RDATA/RVALID (no backpressure on readback).
interface scan_chain_loader_if;
  logic [31:0] WDATA;
  logic        WVALID;
  logic        WREADY;
  logic [31:0] RDATA;
  logic        RVALID;

  modport master (output WDATA, output WVALID, input WREADY, input RDATA, input RVALID);
  modport slave  (input WDATA, input WVALID, output WREADY, output RDATA, output RVALID);
endinterface

// File: rtl/scan_chain_loader.sv
// Serialises 32-bit configuration words MSB-first into a BLE scan chain and
// captures the bits falling out of the tail so old contents can be read back.
// SE is high only in SHIFT, so the chain is frozen across word gaps.
module scan_chain_loader #(
  parameter int CHAIN_LEN = 66,
  parameter int CW        = $clog2(CHAIN_LEN+1)
) (
  input  logic                PCLK,
  input  logic                RESETN,
  input  logic                START,
  input  logic                ABORT,
  output logic                SE,
  output logic                SIN,
  input  logic                SOUT,
  output logic                BUSY,
  output logic                DONE,
  scan_chain_loader_if.slave  bus
);
  // Wide enough to compare the remaining count against 32 for any CHAIN_LEN.
  localparam int RW = (CW > 6) ? CW : 6;

  typedef enum logic [1:0] {IDLE, WAIT_WORD, SHIFT, FINISH} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] remaining_q, remaining_d;
  logic [5:0]    wbits_q, wbits_d;
  logic [31:0]   shreg_q, shreg_d;
  logic [31:0]   rshreg_q, rshreg_d;
  logic [5:0]    rcount_q, rcount_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;

  logic [RW-1:0] rem_w;
  logic          last_bit;
  logic [31:0]   cap_word;
  logic [5:0]    rcount_inc;

  assign rem_w    = RW'(remaining_q);
  assign last_bit = (wbits_q == 6'd1) && (remaining_q == CW'(1));

  // Next-state, shift and readback-capture logic.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    wbits_d     = wbits_q;
    shreg_d     = shreg_q;
    rshreg_d    = rshreg_q;
    rcount_d    = rcount_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    cap_word    = {rshreg_q[30:0], SOUT};
    rcount_inc  = rcount_q + 6'd1;
    case (state_q)
      IDLE: begin
        // START beats a simultaneous ABORT here since ABORT is not looked at.
        if (START) begin
          remaining_d = CW'(CHAIN_LEN);
          rshreg_d    = '0;
          rcount_d    = '0;
          state_d     = WAIT_WORD;
        end
      end
      WAIT_WORD: begin
        if (ABORT) begin
          state_d = IDLE;
        end else if (bus.WVALID) begin
          shreg_d = bus.WDATA;
          wbits_d = (rem_w >= RW'(32)) ? 6'd32 : 6'(remaining_q);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (ABORT) begin
          state_d = IDLE;
        end else begin
          shreg_d     = {shreg_q[30:0], 1'b0};
          wbits_d     = wbits_q - 6'd1;
          remaining_d = remaining_q - CW'(1);
          rshreg_d    = cap_word;
          rcount_d    = rcount_inc;
          // Full word or final bit: publish, left-aligning a partial word.
          if (rcount_inc == 6'd32 || last_bit) begin
            rvalid_d = 1'b1;
            rdata_d  = cap_word << (6'd32 - rcount_inc);
            rcount_d = '0;
            rshreg_d = '0;
          end
          if (wbits_q == 6'd1)
            state_d = (remaining_q == CW'(1)) ? FINISH : WAIT_WORD;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything asynchronously.
  always_ff @(posedge PCLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      wbits_q     <= '0;
      shreg_q     <= '0;
      rshreg_q    <= '0;
      rcount_q    <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      wbits_q     <= wbits_d;
      shreg_q     <= shreg_d;
      rshreg_q    <= rshreg_d;
      rcount_q    <= rcount_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
    end
  end

  // Outputs decode registered state only, so reset drops SE without a clock.
  assign SE         = (state_q == SHIFT);
  assign SIN        = SE & shreg_q[31];
  assign BUSY       = (state_q != IDLE);
  assign DONE       = (state_q == FINISH);
  assign bus.WREADY = (state_q == WAIT_WORD);
  assign bus.RDATA  = rdata_q;
  assign bus.RVALID = rvalid_q;
endmodule

// File: tb/tb_scan_chain_loader.sv
// Directed bench: a 66-bit and a 33-bit loader, each driving a behavioural
// scan chain whose tail feeds SOUT back for readback.
module tb_scan_chain_loader;
  logic PCLK = 1'b0, RESETN = 1'b0, START = 1'b0, ABORT = 1'b0;
  logic SE, SIN, SOUT, BUSY, DONE;
  logic START33 = 1'b0, ABORT33 = 1'b0;
  logic SE33, SIN33, SOUT33, BUSY33, DONE33;

  scan_chain_loader_if m ();
  scan_chain_loader_if m33 ();

  scan_chain_loader #(.CHAIN_LEN(66)) dut (
    .PCLK(PCLK), .RESETN(RESETN), .START(START), .ABORT(ABORT),
    .SE(SE), .SIN(SIN), .SOUT(SOUT), .BUSY(BUSY), .DONE(DONE), .bus(m));

  scan_chain_loader #(.CHAIN_LEN(33)) dut33 (
    .PCLK(PCLK), .RESETN(RESETN), .START(START33), .ABORT(ABORT33),
    .SE(SE33), .SIN(SIN33), .SOUT(SOUT33), .BUSY(BUSY33), .DONE(DONE33), .bus(m33));

  always #5 PCLK = ~PCLK;

  localparam logic [65:0] PAT = {32'hA5A5A5A5, 32'h0F0F0F0F, 2'b11};

  // Behavioural chains: shift toward the tail when SE is high.
  logic [65:0] chain   = '0;
  logic [32:0] chain33 = '0;
  assign SOUT   = chain[65];
  assign SOUT33 = chain33[32];
  always @(posedge PCLK) if (SE)   chain   <= {chain[64:0], SIN};
  always @(posedge PCLK) if (SE33) chain33 <= {chain33[31:0], SIN33};

  // Monitors, sampled on the falling edge.
  int cyc = 0;
  int se_cnt = 0, done_cnt = 0, rv_cnt = 0, se33_cnt = 0, rv33_cnt = 0;
  logic [31:0] rv_log [16];
  logic [31:0] rv33_log [16];
  logic [65:0] sin_hist = '0;
  always @(posedge PCLK) cyc <= cyc + 1;
  always @(negedge PCLK) begin
    if (SE) begin
      se_cnt   <= se_cnt + 1;
      sin_hist <= {sin_hist[64:0], SIN};
    end
    if (DONE) done_cnt <= done_cnt + 1;
    if (m.RVALID) begin
      rv_log[rv_cnt % 16] <= m.RDATA;
      rv_cnt <= rv_cnt + 1;
    end
    if (SE33) se33_cnt <= se33_cnt + 1;
    if (m33.RVALID) begin
      rv33_log[rv33_cnt % 16] <= m33.RDATA;
      rv33_cnt <= rv33_cnt + 1;
    end
  end

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic wait_wready(input string tag);
    int b = 0;
    while (m.WREADY !== 1'b1 && b < 100) begin tick(); b++; end
    chk(tag, m.WREADY, 1);
  endtask

  // Full load of three words; gap = WAIT_WORD cycles held with WVALID=0
  // between words; poke = pulse START while busy.
  task automatic run_load(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                          input int gap, input bit poke, output int dur);
    logic [31:0] w [3];
    int t0, b;
    w[0] = w0; w[1] = w1; w[2] = w2;
    START = 1'b1; tick(); START = 1'b0; t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      if (i > 0 && gap > 0) begin
        m.WVALID = 1'b0;
        wait_wready("gap_wready");
        repeat (gap) begin tick(); chk("gap_se_low", SE, 0); end
      end
      m.WVALID = 1'b1; m.WDATA = w[i];
      wait_wready("wready");
      tick();
      chk("wready_in_shift", m.WREADY, 0);
      if (poke && i == 0) begin START = 1'b1; tick(); START = 1'b0; end
    end
    m.WVALID = 1'b0;
    b = 0;
    while (DONE !== 1'b1 && b < 200) begin tick(); b++; end
    chk("done_seen", DONE, 1);
    dur = cyc - t0;
  endtask

  task automatic load33(input logic [31:0] w0, input logic [31:0] w1, output int dur);
    int t0, b;
    START33 = 1'b1; tick(); START33 = 1'b0; t0 = cyc;
    m33.WVALID = 1'b1; m33.WDATA = w0;
    b = 0; while (m33.WREADY !== 1'b1 && b < 100) begin tick(); b++; end
    tick();
    m33.WDATA = w1;
    b = 0; while (m33.WREADY !== 1'b1 && b < 100) begin tick(); b++; end
    chk("l33_wready", m33.WREADY, 1);
    tick();
    m33.WVALID = 1'b0;
    b = 0; while (DONE33 !== 1'b1 && b < 100) begin tick(); b++; end
    chk("l33_done", DONE33, 1);
    dur = cyc - t0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dur, dur0, se0, d0, r0;
    m.WVALID = 1'b0; m.WDATA = '0; m33.WVALID = 1'b0; m33.WDATA = '0;

    // Reset values with RESETN held low.
    tick(); tick();
    chk("rst_se", SE, 0);         chk("rst_sin", SIN, 0);
    chk("rst_wready", m.WREADY, 0); chk("rst_rvalid", m.RVALID, 0);
    chk("rst_done", DONE, 0);     chk("rst_busy", BUSY, 0);
    chk("rst_rdata", m.RDATA, 0);
    RESETN = 1'b1; tick();
    chk("idle_busy", BUSY, 0);    chk("idle_wready", m.WREADY, 0);

    // START accepted -> WREADY next cycle (checked inside via wait), full load.
    se0 = se_cnt; d0 = done_cnt; r0 = rv_cnt;
    run_load(32'hA5A5A5A5, 32'h0F0F0F0F, 32'hC0000000, 0, 1'b0, dur0);
    chk("full_dur", 66'(dur0), 66'd69);
    chk("full_rvalid_with_done", m.RVALID, 1);
    tick();
    chk("full_done_pulse", DONE, 0);
    chk("full_busy_after", BUSY, 0);
    chk("full_se_cycles", 66'(se_cnt - se0), 66'd66);
    chk("full_done_cnt", 66'(done_cnt - d0), 66'd1);
    chk("full_sin_seq", sin_hist, PAT);
    chk("full_ble1", 66'(chain[65:33]), 66'(PAT[65:33]));
    chk("full_ble0", 66'(chain[32:0]), 66'(PAT[32:0]));
    chk("full_rv_cnt", 66'(rv_cnt - r0), 66'd3);

    // Readback of the pattern while loading zeros.
    r0 = rv_cnt;
    run_load(32'h0, 32'h0, 32'h0, 0, 1'b0, dur);
    chk("rb_rvalid_with_done", m.RVALID, 1);
    tick();
    chk("rb_rv_cnt", 66'(rv_cnt - r0), 66'd3);
    chk("rb_word0", rv_log[r0 % 16], 32'hA5A5A5A5);
    chk("rb_word1", rv_log[(r0 + 1) % 16], 32'h0F0F0F0F);
    chk("rb_word2", rv_log[(r0 + 2) % 16], 32'hC0000000);
    chk("rb_chain_zero", chain, 66'd0);
    chk("rb_rdata_hold", m.RDATA, 32'hC0000000);
    chk("rb_rvalid_low", m.RVALID, 0);

    // Backpressure gaps of 5 cycles plus START while busy.
    se0 = se_cnt; d0 = done_cnt;
    run_load(32'hA5A5A5A5, 32'h0F0F0F0F, 32'hC0000000, 5, 1'b1, dur);
    chk("gap_dur_delta", 66'(dur - dur0), 66'd10);
    tick();
    chk("gap_chain", chain, PAT);
    chk("gap_se_cycles", 66'(se_cnt - se0), 66'd66);
    chk("gap_done_cnt", 66'(done_cnt - d0), 66'd1);

    // Asynchronous reset mid-shift.
    START = 1'b1; tick(); START = 1'b0;
    m.WVALID = 1'b1; m.WDATA = 32'hFFFFFFFF;
    wait_wready("mid_wready");
    tick(); tick(); tick();
    chk("mid_se_high", SE, 1);
    RESETN = 1'b0; #1;
    chk("mid_se_async", SE, 0);
    chk("mid_busy", BUSY, 0);     chk("mid_sin", SIN, 0);
    chk("mid_wready", m.WREADY, 0); chk("mid_rvalid", m.RVALID, 0);
    chk("mid_done", DONE, 0);     chk("mid_rdata", m.RDATA, 0);
    m.WVALID = 1'b0;
    tick(); RESETN = 1'b1; tick();
    chk("mid_idle", BUSY, 0);

    // ABORT on the 10th SE cycle of word 1.
    d0 = done_cnt;
    START = 1'b1; tick(); START = 1'b0;
    m.WVALID = 1'b1; m.WDATA = 32'hA5A5A5A5;
    wait_wready("ab_w0"); tick();
    m.WDATA = 32'h0F0F0F0F;
    wait_wready("ab_w1"); tick();
    repeat (9) tick();
    chk("ab_se_10th", SE, 1);
    ABORT = 1'b1; tick(); ABORT = 1'b0; m.WVALID = 1'b0;
    chk("ab_se_low", SE, 0);
    chk("ab_busy", BUSY, 0);
    chk("ab_done", DONE, 0);
    tick();
    chk("ab_no_done", 66'(done_cnt - d0), 66'd0);
    run_load(32'hA5A5A5A5, 32'h0F0F0F0F, 32'hC0000000, 0, 1'b0, dur);
    chk("ab_reload_dur", 66'(dur), 66'd69);
    tick();
    chk("ab_reload_chain", chain, PAT);

    // ABORT with START in IDLE: START wins.
    START = 1'b1; ABORT = 1'b1; tick(); START = 1'b0; ABORT = 1'b0;
    chk("sa_busy", BUSY, 1);
    chk("sa_wready", m.WREADY, 1);
    ABORT = 1'b1; tick(); ABORT = 1'b0;
    chk("sa_abort_idle", BUSY, 0);

    // CHAIN_LEN=33: two words, one bit of the second used.
    se0 = se33_cnt;
    load33(32'hDEADBEEF, 32'h80000000, dur);
    chk("c33_dur", 66'(dur), 66'd35);
    tick();
    chk("c33_se_cycles", 66'(se33_cnt - se0), 66'd33);
    chk("c33_chain", chain33, {32'hDEADBEEF, 1'b1});
    r0 = rv33_cnt;
    load33(32'h12345678, 32'h7FFFFFFF, dur);
    tick();
    chk("c33_rv_cnt", 66'(rv33_cnt - r0), 66'd2);
    chk("c33_rb_word0", rv33_log[r0 % 16], 32'hDEADBEEF);
    chk("c33_rb_final", rv33_log[(r0 + 1) % 16], 32'h80000000);
    chk("c33_chain2", chain33, {32'h12345678, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/scan_chain_loader.md
# scan_chain_loader

Sequencer that programs a chain of BLE configuration cells. It accepts 32-bit configuration words over a valid/ready handshake and serialises them MSB-first onto the chain's scan input. It drives the chain's scan-enable only while a bit is being shifted. It also captures the bits leaving the chain tail, so the old contents can be read back. It sits between the bitstream source (host interface or ROM) and the head of the chain, on the programming clock domain.

## Interface
Parameters:
- CHAIN_LEN, 66: total scan bits in the chain (33 per BLE; default 2 BLEs); must be ≥1.
- CW, $clog2(CHAIN_LEN+1): width of the remaining-bit counter (derived).

Ports:
- PCLK  in  1  programming clock; the only clock; all state changes on rising edge.
- RESETN  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle request to begin a load; honoured only in IDLE.
- ABORT  in  1  synchronous cancel; honoured in any non-IDLE state.
- WDATA  in  32  configuration word; bit 31 is shifted first.
- WVALID  in  1  WDATA is valid.
- WREADY  out  1  block accepts WDATA this cycle.
- SE  out  1  scan enable to the chain (shift/clock-enable).
- SIN  out  1  serial data to the chain head.
- SOUT  in  1  serial data from the chain tail.
- RDATA  out  32  readback word, MSB = first bit captured.
- RVALID  out  1  one-cycle pulse; RDATA is valid. No backpressure.
- BUSY  out  1  a load is in progress.
- DONE  out  1  one-cycle pulse when CHAIN_LEN bits have been shifted.

## Operation
- States: IDLE, WAIT_WORD, SHIFT, FINISH.
- IDLE:
  - START=1 → load `remaining` with CHAIN_LEN, then go to WAIT_WORD.
- WAIT_WORD:
  - WREADY=1.
  - On WVALID&WREADY: load `shreg` with WDATA, set `wbits` = min(32, remaining), go to SHIFT.
- SHIFT, once per cycle:
  - SE=1; SIN = shreg[31].
  - shreg shifts left by 1; wbits and remaining decrement.
  - Capture SOUT into `rshreg` (shift in at LSB) and increment `rcount`.
  - In the cycle where wbits==1: go to FINISH if remaining==1, else WAIT_WORD.
- FINISH: DONE=1 for one cycle, then go to IDLE.
- Stream order:
  - Word 0 bit 31 is the first bit into the chain. The final word uses only its upper (CHAIN_LEN mod 32, or 32) bits; its unused low bits are discarded and never shifted.
  - The first bit shifted ends at the chain tail.
- Readback:
  - When rcount reaches 32, or on the final captured bit, RDATA is registered and RVALID pulses the next cycle.
  - A partial final word is left-aligned with the low bits zero.
  - RDATA holds its value until the next RVALID.
- SE=0 in every state except SHIFT. The chain is frozen during word gaps, so gaps never corrupt it.
- BUSY=1 in WAIT_WORD, SHIFT and FINISH.
- START while BUSY: ignored.
- WVALID outside WAIT_WORD: not accepted (WREADY=0).
- ABORT:
  - Next state is IDLE and SE=0 from the next cycle. No DONE and no further RVALID.
  - The chain holds a partial load.
  - ABORT together with START in IDLE: START wins; ABORT is ignored.
- Reset (async, any state):
  - State goes to IDLE; SE=0, SIN=0, WREADY=0, RVALID=0, DONE=0, BUSY=0, RDATA=0.
  - All counters and shift registers clear.
  - Reset mid-shift drops SE immediately, without waiting for a clock.

## Timing
- SE, SIN, WREADY, BUSY are decoded from registered state and shreg only; none depends combinationally on WVALID, START or SOUT.
- START accepted at edge k: WREADY=1 in cycle k+1.
- Handshake at edge k: SE=1 for cycles k+1 … k+wbits. Shifted bits land in the chain at edges k+1 … k+wbits.
- SOUT is sampled at the same edge that shifts the chain, so it captures the pre-shift tail value (old contents).
- After a full 32-bit word: at least one WAIT_WORD cycle (SE=0). Maximum throughput is 32 bits per 33 cycles.
- DONE is asserted in the cycle after the last SE=1 cycle; IDLE follows one cycle later.
- The final RVALID coincides with DONE.
- START can be accepted in the cycle after DONE, i.e. the first IDLE cycle.

## Test plan
- **Reset values:** assert RESETN=0 mid-SHIFT → SE falls immediately (asynchronously). With RESETN held low, SE/SIN/WREADY/RVALID/DONE/BUSY/RDATA all read 0. After release, state is IDLE.
- **Full load, CHAIN_LEN=66:**
  - Stimulus: START, then words 0xA5A5A5A5, 0x0F0F0F0F, 0xC0000000 presented with WVALID always 1.
  - SIN sequence: 66 bits, ending in "1,1"; exactly 66 SE=1 cycles; DONE pulses once.
  - The chain's two BLE images match the bitstream.
- **Readback:**
  - Preload the chain with the 66-bit pattern above, then load all-zero words.
  - RVALID pulses three times: RDATA = 0xA5A5A5A5, 0x0F0F0F0F, 0xC0000000.
- **Backpressure gaps:**
  - Insert 5 idle cycles of WVALID=0 between words → SE=0 throughout each gap.
  - Final chain contents are identical to the no-gap case; DONE arrives 10 cycles later.
- **ABORT:**
  - ABORT on the 10th SE cycle of word 1 → SE=0 on the next cycle, then IDLE; no DONE, BUSY=0.
  - A following START performs a clean full load.
- **Ignored inputs:**
  - START while BUSY → no restart; remaining is unchanged.
  - WVALID=1 during SHIFT → WREADY=0, and the word is taken only in WAIT_WORD.
  - CHAIN_LEN=33 → 2 words, 33 SE cycles, final RDATA low 31 bits are 0.
